// File: rtl/sort_input_loader.sv
// Front end for the 4-entry sorter: debounces the enter button, collects four
// switch values, launches the sort and reports completion.
module sort_input_loader #(
    parameter int DATA_WIDTH = 4,
    parameter int DB_CYCLES  = 500000
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] SW,
    input  logic                  BTN_ENT,
    input  logic                  SORT_DONE,
    output logic [DATA_WIDTH-1:0] A0,
    output logic [DATA_WIDTH-1:0] A1,
    output logic [DATA_WIDTH-1:0] A2,
    output logic [DATA_WIDTH-1:0] A3,
    output logic                  START,
    output logic [1:0]            IDX,
    output logic                  BUSY,
    output logic                  READY
);

    localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    typedef enum logic [2:0] {
        S_COLLECT   = 3'd0,
        S_LAUNCH    = 3'd1,
        S_WAIT_LOW  = 3'd2,
        S_WAIT_HIGH = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    logic             sync1_r;
    logic             sync2_r;
    logic             db_level_r;
    logic [CNT_W-1:0] db_cnt_r;
    logic             press_r;
    logic             mismatch_s;
    logic             db_expire_s;

    state_t                state_r;
    logic [DATA_WIDTH-1:0] a0_r;
    logic [DATA_WIDTH-1:0] a1_r;
    logic [DATA_WIDTH-1:0] a2_r;
    logic [DATA_WIDTH-1:0] a3_r;
    logic [1:0]            idx_r;
    logic                  start_r;
    logic                  busy_r;
    logic                  ready_r;

    // Debounce decision: level disagreement and whether it has lasted long enough
    always_comb begin
        mismatch_s  = 1'b0;
        db_expire_s = 1'b0;
        if (sync2_r != db_level_r) begin
            mismatch_s  = 1'b1;
            db_expire_s = (db_cnt_r == CNT_MAX);
        end else begin
            mismatch_s  = 1'b0;
            db_expire_s = 1'b0;
        end
    end

    // Button synchronizer, debounce counter and rising-edge press pulse
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_r    <= 1'b0;
            sync2_r    <= 1'b0;
            db_level_r <= 1'b0;
            db_cnt_r   <= '0;
            press_r    <= 1'b0;
        end else begin
            sync1_r <= BTN_ENT;
            sync2_r <= sync1_r;
            if (db_expire_s) begin
                // Only a 0->1 flip of the debounced level is a press
                db_level_r <= sync2_r;
                db_cnt_r   <= '0;
                press_r    <= sync2_r;
            end else if (mismatch_s) begin
                db_cnt_r <= db_cnt_r + CNT_W'(1);
                press_r  <= 1'b0;
            end else begin
                db_cnt_r <= '0;
                press_r  <= 1'b0;
            end
        end
    end

    // Entry collection / launch / completion FSM with registered output decodes
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= S_COLLECT;
            a0_r    <= '0;
            a1_r    <= '0;
            a2_r    <= '0;
            a3_r    <= '0;
            idx_r   <= 2'd0;
            start_r <= 1'b0;
            busy_r  <= 1'b0;
            ready_r <= 1'b0;
        end else begin
            case (state_r)
                S_COLLECT: begin
                    busy_r  <= 1'b0;
                    ready_r <= 1'b0;
                    if (press_r) begin
                        case (idx_r)
                            2'd0:    a0_r <= SW;
                            2'd1:    a1_r <= SW;
                            2'd2:    a2_r <= SW;
                            2'd3:    a3_r <= SW;
                            default: a0_r <= a0_r;
                        endcase
                        if (idx_r == 2'd3) begin
                            state_r <= S_LAUNCH;
                            idx_r   <= 2'd0;
                            start_r <= 1'b1;
                        end else begin
                            idx_r   <= idx_r + 2'd1;
                            start_r <= 1'b0;
                        end
                    end else begin
                        start_r <= 1'b0;
                    end
                end
                S_LAUNCH: begin
                    state_r <= S_WAIT_LOW;
                    start_r <= 1'b0;
                    busy_r  <= 1'b1;
                    ready_r <= 1'b0;
                end
                S_WAIT_LOW: begin
                    // A done flag left over from the previous run must drop first
                    start_r <= 1'b0;
                    busy_r  <= 1'b1;
                    ready_r <= 1'b0;
                    if (!SORT_DONE) begin
                        state_r <= S_WAIT_HIGH;
                    end else begin
                        state_r <= S_WAIT_LOW;
                    end
                end
                S_WAIT_HIGH: begin
                    start_r <= 1'b0;
                    if (SORT_DONE) begin
                        state_r <= S_DONE;
                        busy_r  <= 1'b0;
                        ready_r <= 1'b1;
                    end else begin
                        state_r <= S_WAIT_HIGH;
                        busy_r  <= 1'b1;
                        ready_r <= 1'b0;
                    end
                end
                S_DONE: begin
                    start_r <= 1'b0;
                    busy_r  <= 1'b0;
                    if (press_r) begin
                        // This press only opens a new round; it writes nothing
                        state_r <= S_COLLECT;
                        a0_r    <= '0;
                        a1_r    <= '0;
                        a2_r    <= '0;
                        a3_r    <= '0;
                        idx_r   <= 2'd0;
                        ready_r <= 1'b0;
                    end else begin
                        state_r <= S_DONE;
                        ready_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= S_COLLECT;
                    idx_r   <= 2'd0;
                    start_r <= 1'b0;
                    busy_r  <= 1'b0;
                    ready_r <= 1'b0;
                end
            endcase
        end
    end

    assign A0    = a0_r;
    assign A1    = a1_r;
    assign A2    = a2_r;
    assign A3    = a3_r;
    assign IDX   = idx_r;
    assign START = start_r;
    assign BUSY  = busy_r;
    assign READY = ready_r;

endmodule

// File: tb/tb_sort_input_loader.sv
// Directed bench for sort_input_loader with a short debounce window.
module tb_sort_input_loader;

    localparam int DW = 4;
    localparam int DB = 4;

    logic          CLK;
    logic          RST;
    logic [DW-1:0] SW;
    logic          BTN_ENT;
    logic          SORT_DONE;
    logic [DW-1:0] A0, A1, A2, A3;
    logic          START;
    logic [1:0]    IDX;
    logic          BUSY;
    logic          READY;

    sort_input_loader #(.DATA_WIDTH(DW), .DB_CYCLES(DB)) dut (
        .CLK(CLK), .RST(RST), .SW(SW), .BTN_ENT(BTN_ENT), .SORT_DONE(SORT_DONE),
        .A0(A0), .A1(A1), .A2(A2), .A3(A3),
        .START(START), .IDX(IDX), .BUSY(BUSY), .READY(READY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [DW-1:0] sw;
        logic [1:0]    idx;
        logic [DW-1:0] a0, a1, a2, a3;
    } vec_t;

    vec_t vecs[4];

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    int start_cnt = 0;
    int start_cyc = -1;
    int idx_cyc = -1;
    int busy_after = 0;
    logic [1:0] last_idx = 2'd0;
    int first_k;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
        if (START === 1'b1) begin
            start_cnt++;
            start_cyc = cyc;
        end
        if (cyc == start_cyc + 1) busy_after = int'(BUSY);
        if (IDX !== last_idx) begin
            idx_cyc  = cyc;
            last_idx = IDX;
        end
    endtask

    task automatic press(input logic [DW-1:0] v);
        SW = v;
        BTN_ENT = 1'b1;
        repeat (8) tick();
        BTN_ENT = 1'b0;
        repeat (10) tick();
    endtask

    task automatic check_all(input string tag, input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                             input logic [DW-1:0] e2, input logic [DW-1:0] e3, input logic [1:0] eidx);
        check({tag, ".A0"}, 32'(A0), 32'(e0));
        check({tag, ".A1"}, 32'(A1), 32'(e1));
        check({tag, ".A2"}, 32'(A2), 32'(e2));
        check({tag, ".A3"}, 32'(A3), 32'(e3));
        check({tag, ".IDX"}, 32'(IDX), 32'(eidx));
    endtask

    initial begin
        vecs[0] = '{sw: 4'h9, idx: 2'd1, a0: 4'h9, a1: 4'h0, a2: 4'h0, a3: 4'h0};
        vecs[1] = '{sw: 4'h3, idx: 2'd2, a0: 4'h9, a1: 4'h3, a2: 4'h0, a3: 4'h0};
        vecs[2] = '{sw: 4'hC, idx: 2'd3, a0: 4'h9, a1: 4'h3, a2: 4'hC, a3: 4'h0};
        vecs[3] = '{sw: 4'h1, idx: 2'd0, a0: 4'h9, a1: 4'h3, a2: 4'hC, a3: 4'h1};

        RST = 1'b1; SW = 4'h0; BTN_ENT = 1'b0; SORT_DONE = 1'b1;
        tick(); tick();
        check_all("reset", 4'h0, 4'h0, 4'h0, 4'h0, 2'd0);
        check("reset.START", 32'(START), 32'd0);
        check("reset.BUSY", 32'(BUSY), 32'd0);
        check("reset.READY", 32'(READY), 32'd0);
        RST = 1'b0;
        tick();

        // Bounces shorter than the debounce window
        SW = 4'h9;
        BTN_ENT = 1'b1; repeat (3) tick();
        BTN_ENT = 1'b0; repeat (2) tick();
        BTN_ENT = 1'b1; repeat (3) tick();
        BTN_ENT = 1'b0; repeat (10) tick();
        check("bounce.IDX", 32'(IDX), 32'd0);
        check("bounce.A0", 32'(A0), 32'd0);

        for (int i = 0; i < 4; i++) begin
            press(vecs[i].sw);
            check_all($sformatf("entry%0d", i), vecs[i].a0, vecs[i].a1, vecs[i].a2, vecs[i].a3, vecs[i].idx);
        end
        check("start.count", 32'(start_cnt), 32'd1);
        check("start.cycle", 32'(start_cyc), 32'(idx_cyc));
        check("start.busy_next", 32'(busy_after), 32'd1);

        // Stale done flag held high: must stay busy
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stale.BUSY", 32'(BUSY), 32'd1);
            check("stale.READY", 32'(READY), 32'd0);
        end
        SORT_DONE = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("low.BUSY", 32'(BUSY), 32'd1);
            check("low.READY", 32'(READY), 32'd0);
        end

        // Press while waiting for completion is ignored
        press(4'hF);
        check_all("waitpress", 4'h9, 4'h3, 4'hC, 4'h1, 2'd0);
        check("waitpress.start_count", 32'(start_cnt), 32'd1);
        check("waitpress.BUSY", 32'(BUSY), 32'd1);
        check("waitpress.READY", 32'(READY), 32'd0);

        SORT_DONE = 1'b1;
        tick();
        check("done.READY", 32'(READY), 32'd1);
        check("done.BUSY", 32'(BUSY), 32'd0);
        repeat (3) tick();
        check("done.hold_READY", 32'(READY), 32'd1);

        press(4'h5);
        check_all("restart", 4'h0, 4'h0, 4'h0, 4'h0, 2'd0);
        check("restart.READY", 32'(READY), 32'd0);
        check("restart.BUSY", 32'(BUSY), 32'd0);

        press(4'h7);
        check("new.A0", 32'(A0), 32'h7);
        check("new.IDX", 32'(IDX), 32'd1);
        press(4'h5);
        check("new.A1", 32'(A1), 32'h5);
        check("new.IDX2", 32'(IDX), 32'd2);

        // Reset mid-collection with the button held through it
        SW = 4'h6;
        BTN_ENT = 1'b1;
        RST = 1'b1;
        tick();
        check_all("midrst", 4'h0, 4'h0, 4'h0, 4'h0, 2'd0);
        check("midrst.START", 32'(START), 32'd0);
        check("midrst.BUSY", 32'(BUSY), 32'd0);
        check("midrst.READY", 32'(READY), 32'd0);
        tick();
        RST = 1'b0;
        first_k = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (IDX == 2'd1 && first_k == 0) first_k = k;
        end
        check("held.latency", 32'(first_k), 32'(DB + 3));
        check("held.A0", 32'(A0), 32'h6);
        check("held.once_IDX", 32'(IDX), 32'd1);
        BTN_ENT = 1'b0;
        repeat (10) tick();
        check("held.release_IDX", 32'(IDX), 32'd1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/sort_input_loader.md
Name: sort_input_loader

Overview:
- Front-end stage feeding the 4-entry sort FSM/datapath.
- Collects four DATA_WIDTH-bit values from switches, one per debounced press of an enter button, and presents them on four parallel outputs.
- Issues a one-cycle START to the sorter, then tracks the sorter's done flag and reports completion.
- A further press starts a new entry round.

Parameters:
DATA_WIDTH, 4, width of each entry and of SW
DB_CYCLES, 500000, consecutive stable cycles needed to accept a button level change (minimum 2)

Ports:
CLK  in  1  system clock; all state updates on rising edge
RST  in  1  synchronous, active-high reset
SW  in  DATA_WIDTH  value to capture on the next enter press
BTN_ENT  in  1  raw enter button, asynchronous, active-high
SORT_DONE  in  1  sorter completion flag (level)
A0, A1, A2, A3  out  DATA_WIDTH each  captured entries 0..3 (unsorted) to sorter load inputs
START  out  1  one-cycle pulse telling the sorter to load A0..A3 and begin
IDX  out  2  slot the next press will write (0..3)
BUSY  out  1  high from START until sort completion is seen
READY  out  1  high while sorted result is valid (DONE state)

Behaviour:
- Reset (RST=1 at a clock edge):
  - A0..A3=0, IDX=0, START=0, BUSY=0, READY=0.
  - State=COLLECT; synchronizer flops, debounce counter and debounced level all cleared to 0.
  - RST overrides every other input, including mid-sort.
- Button path:
  - BTN_ENT passes through a 2-flop synchronizer.
  - A counter increments each cycle the synchronized level differs from the debounced level and clears when they match.
  - When the counter reaches DB_CYCLES-1 with a mismatch still present, the debounced level flips and the counter clears.
  - PRESS is a one-cycle pulse on the cycle the debounced level goes 0->1. Release produces no event.
  - Bounces shorter than DB_CYCLES produce no PRESS.
  - A button held through reset yields exactly one PRESS after reset releases.
- States:
  - COLLECT:
    - On PRESS, the entry selected by IDX <= SW, sampled in the PRESS cycle.
    - If IDX=3, go to LAUNCH and IDX<=0; otherwise IDX<=IDX+1.
  - LAUNCH: START=1 for exactly this one cycle; next state WAIT_LOW.
  - WAIT_LOW:
    - BUSY=1; wait for SORT_DONE=0, which discards a stale done flag from the previous run.
    - When SORT_DONE=0, go to WAIT_HIGH.
  - WAIT_HIGH: BUSY=1; when SORT_DONE=1, go to DONE.
  - DONE:
    - READY=1; A0..A3 held.
    - On PRESS: A0..A3<=0, IDX<=0, go to COLLECT. That press is consumed and does not write an entry.
- Outputs: START, BUSY and READY are registered decodes of state. BUSY is high in WAIT_LOW and WAIT_HIGH only.
- PRESS in LAUNCH, WAIT_LOW or WAIT_HIGH is ignored.
- A0..A3 are never modified outside COLLECT writes, the DONE->COLLECT clear, and reset.
- Latency from a clean BTN_ENT rise to the PRESS cycle: 2 synchronizer cycles + DB_CYCLES.
- Latency from the 4th PRESS to START high: 1 cycle.
- No arithmetic beyond the 2-bit IDX increment, which wraps 3->0, and the debounce counter. Size the debounce counter to clog2(DB_CYCLES).

Test Plan:
- DB_CYCLES=4, RST for 2 cycles:
  - -> all outputs 0, IDX=0.
  - Press/release four times with SW=9,3,C,1 -> A0..A3=9,3,C,1.
  - START high exactly one cycle, one cycle after the 4th PRESS; BUSY=1 the following cycle.
- Bounce BTN_ENT high 3 cycles, low 2, high 3, then low -> no PRESS, IDX stays 0. Then hold high 8 cycles -> exactly one write, IDX=1.
- After START, hold SORT_DONE=1 for 5 cycles, then 0 for 3, then 1:
  - -> state stays WAIT_LOW while SORT_DONE=1; READY rises only after the 0->1 sequence.
  - BUSY falls in the same cycle READY rises.
- Press during WAIT_HIGH with SW=F -> A0..A3 unchanged, IDX=0, no START.
- In DONE, press -> A0..A3=0, IDX=0, READY=0, state COLLECT. The next press with SW=7 writes A0=7.
- Assert RST after two entries (IDX=2) -> all outputs 0 next cycle. A held BTN_ENT produces exactly one PRESS after DB_CYCLES+2 cycles, writing A0.
